// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the HH:MM:SS time-setting controller.
package clock_pkg;

  localparam int TIME_W = 24;

  // KEY bit assignments
  localparam int KEY_MODE = 0;  // mode / commit
  localparam int KEY_NEXT = 1;  // next field
  localparam int KEY_INC  = 2;  // increment
  localparam int KEY_DEC  = 3;  // decrement

  // Two-digit BCD field limits
  localparam logic [7:0] HRS_MAX = 8'h23;
  localparam logic [7:0] MS_MAX  = 8'h59;

  // Digit blanking per field, [5]=HEX5 .. [0]=HEX0
  localparam logic [5:0] BLANK_HRS = 6'b110000;
  localparam logic [5:0] BLANK_MIN = 6'b001100;
  localparam logic [5:0] BLANK_SEC = 6'b000011;

  typedef enum logic [2:0] {
    ST_DISP,
    ST_SET_HRS,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    FLD_HRS,
    FLD_MIN,
    FLD_SEC
  } field_t;

  // Field being edited in a given state (HRS outside the set states).
  function automatic field_t state_field(input state_t s);
    field_t f;
    case (s)
      ST_SET_MIN: f = FLD_MIN;
      ST_SET_SEC: f = FLD_SEC;
      default:    f = FLD_HRS;
    endcase
    return f;
  endfunction

  // Digits to blank when the given field is in its "off" blink phase.
  function automatic logic [5:0] field_mask(input field_t f);
    logic [5:0] m;
    case (f)
      FLD_MIN: m = BLANK_MIN;
      FLD_SEC: m = BLANK_SEC;
      default: m = BLANK_HRS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_press.sv
// One push-button: 2-flop synchronizer, falling-edge detect, post-press lockout.
// press is a registered one-cycle pulse, two edges after the key is first sampled low.
module key_press
  import clock_pkg::*;
#(
  parameter int LOCKOUT_TICKS = 240_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int LW = $clog2(LOCKOUT_TICKS + 1);

  logic          sync_a;
  logic          sync_b;
  logic          last;
  logic [LW-1:0] lock;
  logic          fall;
  logic          accept;

  // Active-low key: a press is a 1->0 transition of the synchronized level.
  assign fall   = last & ~sync_b;
  assign accept = fall && (lock == '0);

  // Synchronizer, edge register, press pulse and lockout countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      last   <= 1'b1;
      press  <= 1'b0;
      lock   <= '0;
    end else begin
      sync_a <= key;
      sync_b <= sync_a;
      last   <= sync_b;
      press  <= accept;
      if (accept) begin
        lock <= LW'(LOCKOUT_TICKS);
      end else if (lock != '0) begin
        lock <= lock - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: runs/freezes the timekeeper, edits HH:MM:SS
// through a set-mode FSM, loads the edited time back and blinks the field
// being edited.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_CENTISEC = 600_000,
  parameter int BLINK_CENTISECS    = 50,
  parameter int LOCKOUT_TICKS      = 240_000
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic [3:0]        KEY,
  input  logic [TIME_W-1:0] cur_time,
  output logic              run_en,
  output logic              load,
  output logic [TIME_W-1:0] load_time,
  output logic              set_mode,
  output logic [TIME_W-1:0] disp_time,
  output logic [5:0]        blank
);

  localparam int PW = (TICKS_PER_CENTISEC > 1) ? $clog2(TICKS_PER_CENTISEC) : 1;
  localparam int CW = (BLINK_CENTISECS > 1) ? $clog2(BLINK_CENTISECS) : 1;

  // One BCD step of a two-digit field, wrapping between 00 and max.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] max,
                                          input logic       inc);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] r;
    hi = v[7:4];
    lo = v[3:0];
    if (inc) begin
      if (v == max)      r = 8'h00;
      else if (lo == 9)  r = {hi + 4'd1, 4'd0};
      else               r = {hi, lo + 4'd1};
    end else begin
      if (v == 8'h00)    r = max;
      else if (lo == 0)  r = {hi - 4'd1, 4'd9};
      else               r = {hi, lo - 4'd1};
    end
    return r;
  endfunction

  logic [3:0]        press_raw;
  logic [3:0]        press;
  state_t            state_q;
  state_t            state_d;
  field_t            field;
  logic [TIME_W-1:0] edit_q;
  logic              do_capture;
  logic              do_step;
  logic              step_inc;
  logic              blink_clr;
  logic [PW-1:0]     presc_q;
  logic [CW-1:0]     centi_q;
  logic              phase_q;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_press #(
      .LOCKOUT_TICKS(LOCKOUT_TICKS)
    ) u_key (
      .clk  (clk),
      .rst_n(RESET_N),
      .key  (KEY[i]),
      .press(press_raw[i])
    );
  end

  // Same-cycle presses: keep only the highest-priority key (KEY0 first).
  always_comb begin
    press = 4'b0000;
    if (press_raw[KEY_MODE])      press[KEY_MODE] = 1'b1;
    else if (press_raw[KEY_NEXT]) press[KEY_NEXT] = 1'b1;
    else if (press_raw[KEY_INC])  press[KEY_INC]  = 1'b1;
    else if (press_raw[KEY_DEC])  press[KEY_DEC]  = 1'b1;
  end

  assign field = state_field(state_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!RESET_N) state_q <= ST_DISP;
    else          state_q <= state_d;
  end

  // Next state and edit/blink actions from the filtered presses.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_step    = 1'b0;
    step_inc   = 1'b0;
    blink_clr  = 1'b0;
    case (state_q)
      ST_DISP: begin
        if (press[KEY_MODE]) begin
          state_d    = ST_SET_HRS;
          do_capture = 1'b1;
          blink_clr  = 1'b1;
        end
      end
      ST_SET_HRS, ST_SET_MIN, ST_SET_SEC: begin
        if (press[KEY_MODE]) begin
          state_d = ST_COMMIT;
        end else if (press[KEY_NEXT]) begin
          blink_clr = 1'b1;
          case (state_q)
            ST_SET_HRS: state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default:    state_d = ST_SET_HRS;
          endcase
        end else if (press[KEY_INC]) begin
          do_step   = 1'b1;
          step_inc  = 1'b1;
          blink_clr = 1'b1;
        end else if (press[KEY_DEC]) begin
          do_step   = 1'b1;
          blink_clr = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_DISP;
      default:   state_d = ST_DISP;
    endcase
  end

  // Edit register: snapshot of cur_time on entry, stepped field by field.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      edit_q <= '0;
    end else if (do_capture) begin
      edit_q <= cur_time;
    end else if (do_step) begin
      case (field)
        FLD_MIN: edit_q[15:8]  <= bcd_step(edit_q[15:8], MS_MAX, step_inc);
        FLD_SEC: edit_q[7:0]   <= bcd_step(edit_q[7:0], MS_MAX, step_inc);
        default: edit_q[23:16] <= bcd_step(edit_q[23:16], HRS_MAX, step_inc);
      endcase
    end
  end

  // Blink timebase; restarts visible whenever the user touches the field.
  always_ff @(posedge clk) begin
    if (!RESET_N || blink_clr) begin
      presc_q <= '0;
      centi_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PW'(TICKS_PER_CENTISEC - 1)) begin
      presc_q <= '0;
      if (centi_q == CW'(BLINK_CENTISECS - 1)) begin
        centi_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        centi_q <= centi_q + 1'b1;
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Outputs decoded from state, edit, phase and cur_time only.
  always_comb begin
    run_en    = (state_q == ST_DISP);
    load      = (state_q == ST_COMMIT);
    load_time = edit_q;
    set_mode  = (state_q == ST_SET_HRS) || (state_q == ST_SET_MIN) ||
                (state_q == ST_SET_SEC);
    disp_time = (state_q == ST_DISP) ? cur_time : edit_q;
    blank     = (set_mode && phase_q) ? field_mask(field) : 6'b000000;
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed key sequences; committed times go into
// an expected queue that a monitor checks against every load pulse.
module tb_clock_set_ctrl;

  logic        clk;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic [23:0] cur_time;
  logic        run_en;
  logic        load;
  logic [23:0] load_time;
  logic        set_mode;
  logic [23:0] disp_time;
  logic [5:0]  blank;

  logic [23:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  clock_set_ctrl #(
    .TICKS_PER_CENTISEC(4),
    .BLINK_CENTISECS   (2),
    .LOCKOUT_TICKS     (8)
  ) dut (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .KEY      (KEY),
    .cur_time (cur_time),
    .run_en   (run_en),
    .load     (load),
    .load_time(load_time),
    .set_mode (set_mode),
    .disp_time(disp_time),
    .blank    (blank)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every load pulse must match the next committed value, last one cycle,
  // and be followed by a running timekeeper.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) begin
        check("load_one_cycle", {23'b0, load}, 24'h0);
        check("run_en_after_commit", {23'b0, run_en}, 24'h1);
      end
      if (load === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load: load_time %h with nothing committed", load_time);
        end else begin
          check("load_time", load_time, exp_q.pop_front());
        end
      end
      prev = (load === 1'b1);
    end
  end

  // Press and release the keys in mask, then wait out the lockout.
  task automatic press(input logic [3:0] mask);
    @(posedge clk); #1;
    KEY = ~mask;
    repeat (3) @(posedge clk);
    #1 KEY = 4'hF;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  // KEY2 chatter: low, high, low inside the lockout window.
  task automatic bounce_inc();
    @(posedge clk); #1;
    KEY = 4'b1011;
    repeat (2) @(posedge clk);
    #1 KEY = 4'hF;
    repeat (2) @(posedge clk);
    #1 KEY = 4'b1011;
    repeat (3) @(posedge clk);
    #1 KEY = 4'hF;
    repeat (14) @(posedge clk);
    @(negedge clk);
  endtask

  // Press KEY0 from DISP and wait (bounded) for set mode; optionally check blink.
  task automatic enter_set(input bit chk_blink);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    KEY = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (set_mode === 1'b1) begin
        lat = i;
        break;
      end
    end
    KEY = 4'hF;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL enter_set_timeout: set_mode still %b after 20 cycles", set_mode);
    end else begin
      check("run_en_in_set", {23'b0, run_en}, 24'h0);
      if (chk_blink) begin
        check("press_latency", 24'(lat), 24'd4);
        check("blank_c0", {18'b0, blank}, 24'h0);
        repeat (7) @(negedge clk);
        check("blank_c7", {18'b0, blank}, 24'h0);
        @(negedge clk);
        check("blank_c8", {18'b0, blank}, {18'b0, 6'b110000});
        repeat (7) @(negedge clk);
        check("blank_c15", {18'b0, blank}, {18'b0, 6'b110000});
        @(negedge clk);
        check("blank_c16", {18'b0, blank}, 24'h0);
      end
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    KEY      = 4'hF;
    RESET_N  = 1'b0;
    cur_time = 24'h123456;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_run_en", {23'b0, run_en}, 24'h1);
    check("rst_load", {23'b0, load}, 24'h0);
    check("rst_set_mode", {23'b0, set_mode}, 24'h0);
    check("rst_blank", {18'b0, blank}, 24'h0);
    check("rst_disp", disp_time, 24'h123456);
    #1 RESET_N = 1'b1;
    cur_time = 24'h000102;
    @(negedge clk);
    check("disp_follows", disp_time, 24'h000102);
    cur_time = 24'h123456;

    // Session A: blink, field cycling, commit
    enter_set(1'b1);
    check("set_disp", disp_time, 24'h123456);
    press(4'b0010);
    press(4'b0100);
    check("min_inc", disp_time, 24'h123556);
    press(4'b0010);
    press(4'b0010);
    press(4'b0100);
    check("cycle_to_hrs", disp_time, 24'h133556);
    exp_q.push_back(24'h133556);
    press(4'b0001);
    check("back_to_disp", {23'b0, set_mode}, 24'h0);

    // Session B: wrap boundaries, simultaneous keys, bounce
    cur_time = 24'h230045;
    enter_set(1'b0);
    press(4'b0100);
    check("hrs_23_inc", disp_time, 24'h000045);
    press(4'b1000);
    check("hrs_00_dec", disp_time, 24'h230045);
    press(4'b0010);
    press(4'b1000);
    check("min_00_dec", disp_time, 24'h235945);
    press(4'b0100);
    check("min_59_inc", disp_time, 24'h230045);
    press(4'b1100);
    check("inc_beats_dec", disp_time, 24'h230145);
    bounce_inc();
    check("bounce_single", disp_time, 24'h230245);
    exp_q.push_back(24'h230245);
    press(4'b0001);

    // Session C: 09 -> 10, then reset with edits pending
    cur_time = 24'h120930;
    enter_set(1'b0);
    press(4'b0010);
    press(4'b0100);
    check("min_09_inc", disp_time, 24'h121030);
    @(posedge clk); #1;
    RESET_N = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_set_mode", {23'b0, set_mode}, 24'h0);
    check("midrst_run_en", {23'b0, run_en}, 24'h1);
    check("midrst_blank", {18'b0, blank}, 24'h0);
    check("midrst_disp", disp_time, 24'h120930);
    #1 RESET_N = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 24'(exp_q.size()), 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
